note_tone_gen: RTL and testbench

Tone-synthesis stage that sits directly downstream of the auto-play melody sequencers. It consumes the 5-bit note code and the beat strobe, and drives the piezo buzzer with a square wave at the note's pitch. It inserts a short silent articulation gap whenever a note is re-struck, so repeated notes are audible as separate notes. It also supports a phase-coherent mute.

---
 rtl/note_pkg.sv | 44 ++++
 rtl/tone_divider.sv | 28 ++
 rtl/note_tone_gen.sv | 95 +++++++++
 tb/tb_note_tone_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note tone generator: note codes, pitch table,
// half-period helper and FSM state encoding.
package note_pkg;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_C4   = 5'd1;
  localparam logic [4:0] NOTE_D4   = 5'd2;
  localparam logic [4:0] NOTE_E4   = 5'd3;
  localparam logic [4:0] NOTE_F4   = 5'd4;
  localparam logic [4:0] NOTE_G4   = 5'd5;
  localparam logic [4:0] NOTE_A4   = 5'd6;
  localparam logic [4:0] NOTE_B4   = 5'd7;
  localparam logic [4:0] NOTE_C5   = 5'd8;
  localparam logic [4:0] NOTE_D5   = 5'd9;
  localparam logic [4:0] NOTE_E5   = 5'd10;
  localparam logic [4:0] NOTE_F5   = 5'd11;
  localparam logic [4:0] NOTE_G5   = 5'd12;
  localparam logic [4:0] NOTE_A5   = 5'd13;
  localparam logic [4:0] NOTE_B5   = 5'd14;
  localparam logic [4:0] NOTE_C6   = 5'd15;
  localparam logic [4:0] NOTE_MAX  = 5'd15;

  // Equal-tempered pitches in centihertz, indexed by note code (0 = rest)
  localparam int unsigned FREQ_CHZ [16] = '{
    0,
    26163, 29366, 32963, 34923, 39200, 44000, 49388,
    52325, 58733, 65926, 69846, 78399, 88000, 98777,
    104650
  };

  typedef enum logic [1:0] {
    ST_REST,
    ST_GAP,
    ST_TONE
  } state_t;

  // Clock cycles per half period of the note's square wave; 0 for rests
  function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                  input int unsigned code);
    if (code == 0 || code > 15) return 64'd0;
    return (clk_hz * 64'd50) / 64'(FREQ_CHZ[code[3:0]]);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing the square-wave phase bit; held at zero
// whenever disabled or restarted.
module tone_divider #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             enable,
  input  logic [CNT_W-1:0] half,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || !enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == half - CNT_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Piezo tone generator: latches beat-strobed note codes, inserts an
// articulation gap on re-struck notes and drives a phase-coherent muted buzzer.
import note_pkg::*;

module note_tone_gen #(
  parameter longint unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned     GAP_CYCLES = 2_500_000,
  parameter int unsigned     CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat,
  input  logic [4:0] note,
  input  logic       mute,
  output logic       buzzer,
  output logic [4:0] cur_note,
  output logic       tone_active
);

  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [4:0]       note_d;
  logic [4:0]       note_n;
  logic [CNT_W-1:0] gap_cnt, gap_d;
  logic [CNT_W-1:0] half_sel;
  logic             phase;

  // Half periods are fixed at elaboration; the mux below is just a small ROM
  logic [CNT_W-1:0] half_rom [16];
  for (genvar g = 0; g < 16; g++) begin : g_rom
    localparam longint unsigned H = half_period(CLK_HZ, g);
    assign half_rom[g] = CNT_W'(H);
  end

  assign note_n   = (note > NOTE_MAX) ? NOTE_REST : note;
  assign half_sel = half_rom[cur_note[3:0]];

  always_comb begin
    state_d = state_q;
    note_d  = cur_note;
    gap_d   = gap_cnt;
    unique case (state_q)
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = ST_TONE;
          gap_d   = '0;
        end else begin
          gap_d = gap_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // A beat overrides whatever the current state would have done
    if (beat) begin
      note_d = note_n;
      gap_d  = '0;
      if (note_n == NOTE_REST)
        state_d = ST_REST;
      else if (note_n == cur_note && GAP_CYCLES > 0)
        state_d = ST_GAP;
      else
        state_d = ST_TONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REST;
      cur_note <= '0;
      gap_cnt  <= '0;
      buzzer   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_note <= note_d;
      gap_cnt  <= gap_d;
      buzzer   <= phase & ~mute;
    end
  end

  assign tone_active = (state_q == ST_TONE);

  tone_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (beat),
    .enable  (state_q == ST_TONE),
    .half    (half_sel),
    .phase   (phase)
  );

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen at a scaled-down clock rate so whole
// waveforms fit in a short run.
module tb_note_tone_gen;

  localparam longint unsigned CLK_HZ = 500_000;
  localparam int unsigned     GAP    = 100;
  // Hand-computed half periods at 500 kHz: 25e6 / freq_cHz, truncated
  localparam int H_A4 = 568;
  localparam int H_C5 = 477;
  localparam int H_G4 = 637;
  localparam int H_B4 = 506;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       beat = 1'b0;
  logic       mute = 1'b0;
  logic [4:0] note = 5'd0;
  logic       buzzer;
  logic [4:0] cur_note;
  logic       tone_active;

  note_tone_gen #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP),
    .CNT_W      (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .beat        (beat),
    .note        (note),
    .mute        (mute),
    .buzzer      (buzzer),
    .cur_note    (cur_note),
    .tone_active (tone_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   t;
    logic v;
  } ev_t;

  ev_t  q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference waveform state: tone entry edge, half period, mute window
  int   m_E    = 0;
  int   m_half = 0;
  int   m_mon  = -1;
  int   m_moff = -1;
  logic m_last = 1'b0;

  function automatic logic model_buzz(input int t);
    logic ph;
    ph = 1'b0;
    if (m_half != 0 && t - 1 >= m_E)
      ph = (((t - 1 - m_E) / m_half) % 2) == 1;
    return ph && !(t >= m_mon && t < m_moff);
  endfunction

  task automatic model_push(input logic b);
    if (b != m_last) q.push_back('{t: cyc, v: b});
    m_last = b;
  endtask

  task automatic edge_step();
    mute = (cyc + 1 >= m_mon) && (cyc + 1 < m_moff);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      edge_step();
      model_push(model_buzz(cyc));
    end
  endtask

  task automatic strike(input int code, input int dur, input int half,
                        input int gap, input int exp_note);
    int b;
    note = code[4:0];
    beat = 1'b1;
    edge_step();
    beat = 1'b0;
    b = cyc;
    model_push(model_buzz(b));
    m_E    = b + gap;
    m_half = half;
    check("cur_note", int'(cur_note), exp_note);
    check("tone_active_at_beat", int'(tone_active), (half != 0 && gap == 0) ? 1 : 0);
    for (int i = 1; i < dur; i++) begin
      edge_step();
      model_push(model_buzz(cyc));
      if (gap > 0 && cyc == b + gap - 1) check("tone_active_gap_end", int'(tone_active), 0);
      if (gap > 0 && cyc == b + gap)     check("tone_active_gap_exit", int'(tone_active), 1);
    end
  endtask

  logic prev_buz = 1'b0;
  bit   mon_en   = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].t < cyc) begin
        total++;
        bad++;
        $display("FAIL buzzer_missed: no change to %0b at cycle %0d, buzzer=%0b",
                 q[0].v, q[0].t, buzzer);
        void'(q.pop_front());
      end
      if (buzzer !== prev_buz) begin
        total++;
        if (q.size() > 0 && q[0].t == cyc && q[0].v == buzzer) begin
          void'(q.pop_front());
        end else begin
          bad++;
          $display("FAIL buzzer_edge: got %0b at cycle %0d, next expected change at cycle %0d",
                   buzzer, cyc, (q.size() > 0) ? q[0].t : -1);
          if (q.size() > 0 && q[0].t == cyc) void'(q.pop_front());
        end
      end
    end
    prev_buz = buzzer;
  end

  initial begin
    rst = 1'b1;
    repeat (3) edge_step();
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_cur_note", int'(cur_note), 0);
    check("reset_tone_active", int'(tone_active), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(10);

    // A4 from rest: no gap, first rise 569 edges after the beat edge
    strike(6, 3000, H_A4, 0, 6);
    // Re-struck A4: 100-cycle silent gap
    strike(6, 3000, H_A4, GAP, 6);
    // Rest and out-of-range codes
    strike(0, 500, 0, 0, 0);
    strike(20, 500, 0, 0, 0);
    // Note change without gap; the C5 run ends exactly on a toggle edge
    strike(6, 2000, H_A4, 0, 6);
    strike(8, 2 * H_C5, H_C5, 0, 8);
    strike(5, 2000, H_G4, 0, 5);
    // Beats landing inside a gap
    strike(5, 50, H_G4, GAP, 5);
    strike(5, 50, H_G4, GAP, 5);
    strike(7, 2000, H_B4, 0, 7);
    // Mute for 10000 cycles in the middle of an A4 tone
    m_mon  = cyc + 1 + 1800;
    m_moff = m_mon + 10000;
    strike(6, 14000, H_A4, 0, 6);
    m_mon  = -1;
    m_moff = -1;

    // Reset colliding with a beat mid-tone
    rst  = 1'b1;
    beat = 1'b1;
    note = 5'd6;
    edge_step();
    beat   = 1'b0;
    m_half = 0;
    model_push(1'b0);
    check("rst_beat_buzzer", int'(buzzer), 0);
    check("rst_beat_cur_note", int'(cur_note), 0);
    check("rst_beat_tone_active", int'(tone_active), 0);
    edge_step();
    model_push(1'b0);
    rst = 1'b0;
    idle(300);
    check("post_reset_tone_active", int'(tone_active), 0);
    check("post_reset_cur_note", int'(cur_note), 0);

    idle(5);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL buzzer_pending: change to %0b at cycle %0d never seen", q[0].v, q[0].t);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
